// File: rtl/mac_accum_neuron.sv
// Serial signed MAC neuron front end: accumulates N_INPUTS x*w products, adds bias, shifts, saturates to int8.
// Build option: define MAC_ROUND_EN to round half up before the shift (only when SHIFT > 0).
module mac_accum_neuron #(
    parameter int N_INPUTS = 4,
    parameter int SHIFT    = 4,
    parameter int ACC_W    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  w,
    input  logic signed [15:0] bias,
    output logic               out_valid,
    output logic signed [7:0]  out_value
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W:0] MAX8 = 127;
    localparam logic signed [ACC_W:0] MIN8 = -128;

`ifdef MAC_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND_ADD = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
`endif

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Optional half-up rounding, then arithmetic (floor) shift at ACC_W+1 bits.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] t;
        t = s;
`ifdef MAC_ROUND_EN
        t = t + RND_ADD;
`endif
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W:0] r);
        logic signed [7:0] v;
        if (r > MAX8) begin
            v = 8'sd127;
        end else if (r < MIN8) begin
            v = -8'sd128;
        end else begin
            v = r[7:0];
        end
        return v;
    endfunction

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [7:0]       out_value_q, out_value_d;

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   bias_ext;
    logic signed [ACC_W:0]   sum_s;

    always_comb begin
        prod     = 16'(x) * 16'(w);
        prod_ext = {{(ACC_W-16){prod[15]}}, prod};
        acc_ext  = {acc_q[ACC_W-1], acc_q};
        bias_ext = {{(ACC_W-15){bias[15]}}, bias};
        sum_s    = acc_ext + bias_ext;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_value_d = out_value_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Bias is sampled here; input pairs are held off for this one cycle.
                out_value_d = sat8(round_shift(sum_s));
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;

endmodule

// File: tb/tb_mac_accum_neuron.sv
// Directed bench for mac_accum_neuron (N_INPUTS=4, SHIFT=4, ACC_W=20); expectations follow MAC_ROUND_EN.
module tb_mac_accum_neuron;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  x;
    logic signed [7:0]  w;
    logic signed [15:0] bias;
    logic               out_valid;
    logic signed [7:0]  out_value;

    int total = 0;
    int bad   = 0;

    mac_accum_neuron #(
        .N_INPUTS(4),
        .SHIFT   (4),
        .ACC_W   (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .bias     (bias),
        .out_valid(out_valid),
        .out_value(out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One beat: present the pair at negedge, wait for in_ready, let one edge consume it.
    task automatic beat(input logic signed [7:0] xv, input logic signed [7:0] wv);
        int n;
        n = 0;
        @(negedge clk);
        x = xv;
        w = wv;
        in_valid = 1'b1;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic feed4(input logic [31:0] xs, input logic [31:0] ws, input int gap);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            beat(xs[8*i +: 8], ws[8*i +: 8]);
        end
    endtask

    // Full vector with exact latency checks: DONE cycle, pulse cycle, pulse cleared.
    task automatic run_vec(input string tag, input logic [31:0] xs, input logic [31:0] ws,
                           input logic signed [15:0] b, input int gap, input int exp);
        bias = b;
        feed4(xs, ws, gap);
        chk({tag, "_rdy_done"}, int'(in_ready), 0);
        chk({tag, "_vld_early"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, int'(out_valid), 1);
        chk({tag, "_val"}, int'(out_value), exp);
        @(posedge clk);
        #1;
        chk({tag, "_vld_clr"}, int'(out_valid), 0);
        chk({tag, "_hold"}, int'(out_value), exp);
    endtask

    initial begin
        int e_r8, e_rm8;
`ifdef MAC_ROUND_EN
        e_r8  = 1;
        e_rm8 = 0;
`else
        e_r8  = 0;
        e_rm8 = -1;
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        w        = '0;
        bias     = '0;
        #12;
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_val", int'(out_value), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_rdy", int'(in_ready), 1);

        run_vec("basic", {8'sd40, 8'sd30, 8'sd20, 8'sd10}, {4{8'sd1}}, 16'sd0, 0, 6);
        run_vec("sat_pos", {4{8'sd127}}, {4{8'sd127}}, 16'sd0, 0, 127);
        run_vec("sat_neg", {4{-8'sd128}}, {4{8'sd127}}, 16'sd0, 0, -128);
        run_vec("rnd_p8", {8'sd0, 8'sd0, 8'sd0, 8'sd8}, {4{8'sd1}}, 16'sd0, 0, e_r8);
        run_vec("rnd_m8", {8'sd0, 8'sd0, 8'sd0, -8'sd8}, {4{8'sd1}}, 16'sd0, 0, e_rm8);
        run_vec("bias_m32", 32'd0, {4{8'sd1}}, -16'sd32, 0, -2);
        run_vec("bias_2047", 32'd0, {4{8'sd1}}, 16'sd2047, 0, 127);
        run_vec("gaps", {8'sd40, 8'sd30, 8'sd20, 8'sd10}, {4{8'sd1}}, 16'sd0, 3, 6);

        // in_valid held high through DONE: the pair must not be taken in that cycle.
        bias = 16'sd0;
        @(negedge clk);
        x = 8'sd5;
        w = 8'sd1;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_rdy_done", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("hold_vld1", int'(out_valid), 1);
        chk("hold_val1", int'(out_value), 1);
        chk("hold_rdy_back", int'(in_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_no_early", int'(out_valid), 0);
        chk("hold_rdy_done2", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("hold_vld2", int'(out_valid), 1);
        chk("hold_val2", int'(out_value), 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Put a nonzero result on out_value so the reset clear is visible.
        run_vec("pre_rst", {4{8'sd127}}, {4{8'sd127}}, 16'sd0, 0, 127);
        beat(8'sd100, 8'sd100);
        beat(8'sd100, 8'sd100);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", int'(out_valid), 0);
        chk("mid_rst_val", int'(out_value), 0);
        #1;
        reset = 1'b1;
        run_vec("post_rst", {8'sd40, 8'sd30, 8'sd20, 8'sd10}, {4{8'sd1}}, 16'sd0, 0, 6);

        // Reset landing in the DONE cycle drops that result.
        feed4({4{8'sd127}}, {4{8'sd127}}, 0);
        chk("rd_rdy_done", int'(in_ready), 0);
        #1;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rd_vld", int'(out_valid), 0);
        chk("rd_val", int'(out_value), 0);
        chk("rd_rdy", int'(in_ready), 1);
        run_vec("after_rd", {8'sd40, 8'sd30, 8'sd20, 8'sd10}, {4{8'sd1}}, 16'sd0, 0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_accum_neuron.md
# mac_accum_neuron

Serial multiply-accumulate front end of the neuron datapath. Accepts one signed 8-bit activation and weight pair per handshake and accumulates `N_INPUTS` products into a wide signed accumulator. It then adds a bias, arithmetic-shifts, saturates to signed 8 bits, and presents the result with a one-cycle valid pulse. The output feeds the downstream ReLU activation stage directly.

## Interface
Parameters:
- `N_INPUTS`, default 4: products per result; legal range ≥ 1.
- `SHIFT`, default 4: arithmetic right shift applied after the bias add; legal range 0..15.
- `ACC_W`, default 20: accumulator width; must be ≥ 16 + clog2(`N_INPUTS`) + 1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: the `x`/`w` pair is valid this cycle.
- `in_ready`, out, 1: the block can accept a pair this cycle.
- `x`, in, 8 signed: activation.
- `w`, in, 8 signed: weight.
- `bias`, in, 16 signed: bias. Sampled in the DONE cycle.
- `out_valid`, out, 1: one-cycle pulse; `out_value` is new.
- `out_value`, out, 8 signed: saturated result. Holds its value between pulses.

## Operation
- The state machine has two states: ACC and DONE.
- ACC:
  - `in_ready` = 1.
  - On a beat (`in_valid` && `in_ready`):
    - `acc <= acc + x*w`, using a 16-bit signed product sign-extended to `ACC_W`.
    - `cnt <= cnt + 1`.
  - A beat with `cnt == N_INPUTS-1` moves the state to DONE.
  - Cycles with `in_valid` = 0 leave all state unchanged.
- DONE (exactly one cycle):
  - `in_ready` = 0. `in_valid` is ignored; nothing is consumed.
  - Compute `s = acc + sext(bias)` at `ACC_W+1` bits, so the bias add cannot overflow.
  - `r = s >>> SHIFT` (arithmetic).
  - `out_value <= clamp(r, -128, 127)`.
  - `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`, state returns to ACC.
- Accumulation is modular in `ACC_W`. With the legal `ACC_W` it cannot wrap.
- `out_valid` is cleared on the edge after it is set, unconditionally. There is no output backpressure; the downstream stage must accept every pulse.

## Timing
- Reset values (reset low, asynchronous):
  - state = ACC, `acc` = 0, `cnt` = 0.
  - `out_valid` = 0, `out_value` = 0.
  - `in_ready` = 1 as soon as reset is released.
- Latency: last beat accepted at edge k → DONE during cycle k..k+1 → `out_valid` = 1 and the new `out_value` are visible after edge k+1, for one cycle.
- Throughput: one result per `N_INPUTS` + 1 cycles with `in_valid` held high.
- The first beat of the next vector is accepted at edge k+2 at the earliest.
- `bias` must be stable during the DONE cycle.
- Reset mid-vector discards all partial accumulation. The next result reflects only beats accepted after reset is released.
- A reset asserted during DONE suppresses that result: `out_valid` stays 0.

## Configuration
- Macro: `MAC_ROUND_EN`.
- Defined, with `SHIFT` > 0: `s` has 2^(`SHIFT`-1) added before the shift (round half up toward +inf). The addition is carried at `ACC_W+1` bits before saturation.
- Not defined, or `SHIFT` = 0: plain truncating arithmetic shift (floor).
- Interface and timing are identical in both builds.

## Test plan
All cases use `N_INPUTS`=4, `SHIFT`=4, `ACC_W`=20.
- **Basic:** x={10,20,30,40}, w=1 each, bias=0 → one `out_valid` pulse one cycle after DONE, `out_value`=6 in both builds (sum 100).
- **Saturation:**
  - x=127, w=127 ×4 (sum 64516) → 127.
  - x=−128, w=127 ×4 (sum −65024) → −128.
- **Rounding:**
  - x={8,0,0,0}, w=1 each → 0 without `MAC_ROUND_EN`, 1 with it.
  - x={−8,0,0,0} → −1 without `MAC_ROUND_EN`, 0 with it.
- **Bias:** x=0 all beats, bias=−32 → −2. Then bias=+2047 with zero inputs → 127.
- **Gaps and DONE-cycle blocking:**
  - Insert 3 idle cycles between beats of the basic case → result still 6.
  - Hold `in_valid`=1 with x=5, w=1 through the DONE cycle → `in_ready`=0 in that cycle, and the pair is consumed only at the next edge as beat 0.
- **Reset mid-vector:**
  - Accept 2 beats of x=100, w=100, then pulse reset low asynchronously (between edges) → `out_valid`=0, `out_value`=0.
  - Then run the basic case → 6. No residue from the pre-reset beats.
